bool_vector_sequencer: RTL and testbench

Self-checking stimulus/response stage wrapped around the 3-input combinational function block `d = ~((a|b)&c)`. It drives all eight `{a,b,c}` input combinations into the function block and samples the returned `d`. Each sample is compared against a parameterised expected truth table. At the end it reports a mismatch count, a per-vector fail mask and a pass flag to the board-level status logic (LEDs).

---
 rtl/bool_vector_sequencer.sv | 117 +++++++++++
 tb/tb_bool_vector_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bool_vector_sequencer.sv
// Sweeps all eight {a,b,c} combinations through an external 3-input function
// block, compares each returned f_in against EXPECTED and reports the results.
module bool_vector_sequencer #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'b0101_0111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] idx, idx_next;
    logic [2:0] abc, abc_next;
    logic [3:0] settle, settle_next;
    logic [3:0] err_next;
    logic [7:0] mask_next;
    logic       busy_next, done_next, pass_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            abc       <= 3'd0;
            settle    <= 4'd0;
            err_count <= 4'd0;
            fail_mask <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            abc       <= abc_next;
            settle    <= settle_next;
            err_count <= err_next;
            fail_mask <= mask_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
        end
    end

    // Results are only cleared by an accepted start, so DONE holds them indefinitely.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        abc_next    = abc;
        settle_next = settle;
        err_next    = err_count;
        mask_next   = fail_mask;
        busy_next   = busy;
        done_next   = done;
        pass_next   = pass;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = DRIVE;
                    idx_next    = 3'd0;
                    abc_next    = 3'd0;
                    settle_next = 4'd0;
                    err_next    = 4'd0;
                    mask_next   = 8'd0;
                    busy_next   = 1'b1;
                    done_next   = 1'b0;
                    pass_next   = 1'b0;
                end
            end
            DRIVE: begin
                abc_next = idx;
                if (settle == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    settle_next = settle + 4'd1;
                end
            end
            SAMPLE: begin
                if (f_in != EXPECTED[idx]) begin
                    mask_next[idx] = 1'b1;
                    if (err_count < 4'd8) begin
                        err_next = err_count + 4'd1;
                    end
                end
                if (idx == 3'd7) begin
                    state_next = DONE;
                    abc_next   = 3'd0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    pass_next  = (err_next == 4'd0);
                end else begin
                    state_next  = DRIVE;
                    idx_next    = idx + 3'd1;
                    abc_next    = idx + 3'd1;
                    settle_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign {a, b, c} = abc;

endmodule

// File: tb/tb_bool_vector_sequencer.sv
// Checks bool_vector_sequencer against fixed fault vectors and randomized
// fault patterns scored by a truth-table model of ~((a|b)&c).
module tb_bool_vector_sequencer;

    localparam logic [7:0] EXP_TABLE = 8'b0101_0111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       f_in;
    logic       a, b, c, busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;

    logic       start1 = 1'b0;
    logic       f_in1;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err_count1;
    logic [7:0] fail_mask1;

    // mode 0 golden, 1 stuck-at-1, 2 stuck-at-0, 3 golden with per-vector flips
    logic [1:0] mode = 2'd0;
    logic [7:0] flip = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            2'd1:    f_in = 1'b1;
            2'd2:    f_in = 1'b0;
            2'd3:    f_in = ~((a | b) & c) ^ flip[{a, b, c}];
            default: f_in = ~((a | b) & c);
        endcase
    end

    assign f_in1 = ~((a1 | b1) & c1);

    bool_vector_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .f_in(f_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask)
    );

    bool_vector_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .f_in(f_in1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_mask(fail_mask1)
    );

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [7:0] flip;
        logic [3:0] exp_err;
        logic [7:0] exp_mask;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[5];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scores a fault pattern by evaluating the function for every input combination.
    task automatic model_run(input logic [1:0] m, input logic [7:0] fl,
                             output logic [3:0] e_err, output logic [7:0] e_mask,
                             output logic e_pass);
        e_err  = 0;
        e_mask = 0;
        for (int i = 0; i < 8; i++) begin
            int  ia, ib, ic;
            logic fv;
            ia = (i >> 2) & 1;
            ib = (i >> 1) & 1;
            ic = i & 1;
            if (m == 2'd1)      fv = 1'b1;
            else if (m == 2'd2) fv = 1'b0;
            else                fv = !((ia != 0 || ib != 0) && ic != 0);
            if (m == 2'd3) fv = fv ^ fl[i];
            if (fv != EXP_TABLE[i]) begin
                e_mask[i] = 1'b1;
                e_err     = e_err + 4'd1;
            end
        end
        e_pass = (e_err == 0);
    endtask

    // Full run with S=2: checks the stimulus sequence each cycle and the final results at E0+24.
    task automatic apply_stimulus(input string name, input logic [1:0] m, input logic [7:0] fl,
                                  input logic [3:0] e_err, input logic [7:0] e_mask,
                                  input logic e_pass, input int restart_at);
        mode = m;
        flip = fl;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output({name, " cleared err"}, err_count, 0);
        check_output({name, " cleared mask"}, fail_mask, 0);
        check_output({name, " cleared pass"}, pass, 0);
        for (int k = 0; k < 24; k++) begin
            check_output({name, " abc"}, {a, b, c}, k / 3);
            check_output({name, " busy"}, busy, 1);
            check_output({name, " done early"}, done, 0);
            start = (k == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_output({name, " done"}, done, 1);
        check_output({name, " busy end"}, busy, 0);
        check_output({name, " abc end"}, {a, b, c}, 0);
        check_output({name, " pass"}, pass, e_pass);
        check_output({name, " err_count"}, err_count, e_err);
        check_output({name, " fail_mask"}, fail_mask, e_mask);
    endtask

    initial begin
        logic [3:0] e_err;
        logic [7:0] e_mask;
        logic       e_pass;
        int         cyc;

        tbl[0] = '{"golden",  2'd0, 8'h00, 4'd0, 8'h00,        1'b1};
        tbl[1] = '{"stuck1",  2'd1, 8'h00, 4'd3, 8'b1010_1000, 1'b0};
        tbl[2] = '{"stuck0",  2'd2, 8'h00, 4'd5, 8'b0101_0111, 1'b0};
        tbl[3] = '{"flip_v0", 2'd3, 8'h01, 4'd1, 8'h01,        1'b0};
        tbl[4] = '{"flip_all",2'd3, 8'hFF, 4'd8, 8'hFF,        1'b0};

        #1 reset_n = 1'b0;
        #2;
        check_output("reset abc", {a, b, c}, 0);
        check_output("reset flags", {busy, done, pass}, 0);
        check_output("reset err", err_count, 0);
        check_output("reset mask", fail_mask, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            apply_stimulus(tbl[t].name, tbl[t].mode, tbl[t].flip, tbl[t].exp_err,
                           tbl[t].exp_mask, tbl[t].exp_pass, (t == 0) ? 10 : -1);
        end

        for (int r = 0; r < 6; r++) begin
            logic [7:0] fl;
            fl = 8'($urandom);
            model_run(2'd3, fl, e_err, e_mask, e_pass);
            apply_stimulus("random", 2'd3, fl, e_err, e_mask, e_pass,
                           int'($urandom_range(1, 22)));
        end

        // start held high: done lasts one cycle, then a new run begins
        mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        repeat (24) @(posedge clk);
        #1;
        check_output("held done", done, 1);
        @(posedge clk); #1;
        check_output("held restart done", done, 0);
        check_output("held restart busy", busy, 1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_output("held rerun done", done, 1);

        // SETTLE_CYCLES = 1 instance
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_output("s1 latency", cyc, 16);
        check_output("s1 pass", pass1, 1);

        // reset mid-run with a faulty function block
        mode = 2'd2;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_output("midrun err", err_count, 3);
        check_output("midrun mask", fail_mask, 8'b0000_0111);
        #2 reset_n = 1'b0;
        #1;
        check_output("midrun reset abc", {a, b, c}, 0);
        check_output("midrun reset flags", {busy, done, pass}, 0);
        check_output("midrun reset err", err_count, 0);
        check_output("midrun reset mask", fail_mask, 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus("post_reset", 2'd0, 8'h00, 4'd0, 8'h00, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
